mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL take widths from shared defines: WORD_LEN 32 data width; REG_IDX_WIDTH 5 register index width; ADDR_SIZE 32 PC width.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have inputs inValid (1), stall (1) and flush (1): upstream instruction valid, hold stage, kill incoming.
REQ-005 SHALL have inputs inPc (ADDR_SIZE), inRd (REG_IDX_WIDTH), inRegWrite (1) and inWbSel (2): 00 ALU, 01 load, 10 PC+4, 11 immediate.
REQ-006 SHALL have inputs inAluResult, inImm and inMemData (WORD_LEN each) and inMemFunct3 (3).
REQ-007 SHALL have outputs writeEnable (1), writeAddr (REG_IDX_WIDTH), writeData (WORD_LEN) and pc (ADDR_SIZE), driving the register-file write port.
REQ-008 SHALL have outputs fwdValid (1), fwdAddr (REG_IDX_WIDTH) and fwdData (WORD_LEN): bypass to the execute stage.

Function
REQ-009 SHALL capture all in* fields into the WB register on posedge when stall=0; when stall=1 it SHALL hold them.
REQ-010 SHALL apply priority reset > flush > stall > capture; flush loads a bubble (valid=0) even when stall=1.
REQ-011 SHALL have latency 1: outputs reflect the instruction captured at the previous posedge, combinationally from the WB register.
REQ-012 SHALL compute writeData from wbSel: 00 aluResult; 01 extracted load; 10 pc+4 (mod 2^32); 11 imm.
REQ-013 SHALL extract loads from funct3 and byte offset aluResult[1:0]: 000 LB, sign-extended selected byte; 001 LH, sign-extended half aluResult[1]; 010 LW, raw word; 100 LBU and 101 LHU, zero-extended; other funct3 codes pass the raw word.
REQ-014 SHALL ignore aluResult[0] for halfword loads (misalignment is not trapped).
REQ-015 SHALL drive writeEnable = valid & regWrite & (rd != 0) & firstCycle.
REQ-016 SHALL set firstCycle to 1 on each capture of a valid instruction and clear it after one cycle; a stalled instruction writes exactly once.
REQ-017 SHALL drive pc = registered inPc and writeAddr = registered rd for every held cycle.
REQ-018 SHALL drive fwdValid = valid & regWrite & (rd != 0), independent of firstCycle, with fwdAddr = rd and fwdData = writeData.

Reset
REQ-019 SHALL clear on reset: valid, firstCycle, rd, regWrite, wbSel, pc and data fields, and writeEnable, fwdValid, writeAddr, writeData and pc outputs.
REQ-020 SHALL make reset asserted mid-stall discard the held instruction with no write.

Configuration
REQ-021 SHALL, with MEM_WB_INSTRET_EN defined, add a 64-bit output retiredCount, reset to 0, incremented once per valid instruction in its firstCycle, whether or not it writes a register.
REQ-022 SHALL, without MEM_WB_INSTRET_EN, have no retiredCount port and no counter logic.

Structure
REQ-023 SHALL take WORD_LEN, REG_IDX_WIDTH, ADDR_SIZE, the wbSel encodings and the load funct3 encodings from the shared defines file.
REQ-024 SHALL place load extraction in sub-module load_extend: funct3, offset and raw word in; WORD_LEN result out; purely combinational.

Verification
REQ-025 SHALL cover LB: wbSel=01, funct3=000, aluResult=0x1003, memData=0x80FF1234 -> next cycle writeEnable=1, writeData=0xFFFFFF80.
REQ-026 SHALL cover LHU: funct3=101, aluResult=0x2002, memData=0xBEEF0000 -> writeData=0x0000BEEF.
REQ-027 SHALL cover JAL link: wbSel=10, pc=0x00000FFC, rd=1 -> writeData=0x00001000, writeAddr=1.
REQ-028 SHALL cover rd=0: regWrite=1, rd=0, aluResult=0x5 -> writeEnable=0 and fwdValid=0 on every cycle.
REQ-029 SHALL cover stall: instruction rd=5 captured, then stall=1 for 3 cycles -> writeEnable=1 only in the first cycle, fwdValid=1 for all 4; with MEM_WB_INSTRET_EN, retiredCount +1.
REQ-030 SHALL cover flush plus reset: flush=1 with stall=1 -> next cycle valid=0 and no write; reset asserted mid-stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared widths and encodings for the memory/write-back stage and its load extender.
// Also defines the packed write-back register layout used by the top module.
package mem_wb_stage_pkg;

  localparam int WORD_LEN      = 32;
  localparam int REG_IDX_WIDTH = 5;
  localparam int ADDR_SIZE     = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_IMM  = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Everything the stage holds for one instruction; an all-zero value is a bubble.
  typedef struct packed {
    logic                     valid;
    logic                     first;
    logic [REG_IDX_WIDTH-1:0] rd;
    logic                     reg_write;
    wb_sel_e                  wb_sel;
    logic [ADDR_SIZE-1:0]     pc;
    logic [WORD_LEN-1:0]      alu;
    logic [WORD_LEN-1:0]      imm;
    logic [WORD_LEN-1:0]      mem;
    logic [2:0]               funct3;
  } wb_reg_t;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Combinational load-data extractor: selects the byte/halfword addressed by the
// low address bits and sign- or zero-extends it according to funct3.
module load_extend
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]          funct3,
  input  logic [1:0]          offset,
  input  logic [WORD_LEN-1:0] raw,
  output logic [WORD_LEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  function automatic logic [WORD_LEN-1:0] sext8(input logic signed [7:0] b);
    logic signed [WORD_LEN-1:0] r;
    r = b;
    return r;
  endfunction

  function automatic logic [WORD_LEN-1:0] sext16(input logic signed [15:0] h);
    logic signed [WORD_LEN-1:0] r;
    r = h;
    return r;
  endfunction

  function automatic logic [WORD_LEN-1:0] zext8(input logic [7:0] b);
    return WORD_LEN'(b);
  endfunction

  function automatic logic [WORD_LEN-1:0] zext16(input logic [15:0] h);
    return WORD_LEN'(h);
  endfunction

  always_comb begin
    byte_sel = raw[7:0];
    case (offset)
      2'd0: byte_sel = raw[7:0];
      2'd1: byte_sel = raw[15:8];
      2'd2: byte_sel = raw[23:16];
      2'd3: byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    // Halfword selection looks only at bit 1; a misaligned bit 0 is silently ignored.
    half_sel = offset[1] ? raw[31:16] : raw[15:0];
  end

  always_comb begin
    result = raw;
    case (funct3)
      F3_LB:   result = sext8(byte_sel);
      F3_LH:   result = sext16(half_sel);
      F3_LW:   result = raw;
      F3_LBU:  result = zext8(byte_sel);
      F3_LHU:  result = zext16(half_sel);
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/write-back pipeline register: holds one instruction, drives the register
// file write port once per instruction and a bypass path every held cycle.
// Optional retired-instruction counter enabled by defining MEM_WB_INSTRET_EN.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inValid,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [ADDR_SIZE-1:0]     inPc,
  input  logic [REG_IDX_WIDTH-1:0] inRd,
  input  logic                     inRegWrite,
  input  logic [1:0]               inWbSel,
  input  logic [WORD_LEN-1:0]      inAluResult,
  input  logic [WORD_LEN-1:0]      inImm,
  input  logic [WORD_LEN-1:0]      inMemData,
  input  logic [2:0]               inMemFunct3,
  output logic                     writeEnable,
  output logic [REG_IDX_WIDTH-1:0] writeAddr,
  output logic [WORD_LEN-1:0]      writeData,
  output logic [ADDR_SIZE-1:0]     pc,
  output logic                     fwdValid,
  output logic [REG_IDX_WIDTH-1:0] fwdAddr,
  output logic [WORD_LEN-1:0]      fwdData
`ifdef MEM_WB_INSTRET_EN
  ,
  output logic [63:0]              retiredCount
`endif
);

  wb_reg_t             wb_q, wb_d;
  logic [WORD_LEN-1:0] load_data;
  logic [WORD_LEN-1:0] wdata;
  logic                dest_live;

  // Next-state: flush beats stall; a held instruction loses its first-cycle flag.
  always_comb begin
    wb_d       = wb_q;
    wb_d.first = 1'b0;
    if (flush) begin
      wb_d = '0;
    end else if (!stall) begin
      wb_d.valid     = inValid;
      wb_d.first     = inValid;
      wb_d.rd        = inRd;
      wb_d.reg_write = inRegWrite;
      wb_d.wb_sel    = wb_sel_e'(inWbSel);
      wb_d.pc        = inPc;
      wb_d.alu       = inAluResult;
      wb_d.imm       = inImm;
      wb_d.mem       = inMemData;
      wb_d.funct3    = inMemFunct3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  // Write-back stage boundary: everything below is combinational from wb_q.
  load_extend u_load_extend (
    .funct3 (wb_q.funct3),
    .offset (wb_q.alu[1:0]),
    .raw    (wb_q.mem),
    .result (load_data)
  );

  always_comb begin
    wdata = wb_q.alu;
    case (wb_q.wb_sel)
      WB_ALU:  wdata = wb_q.alu;
      WB_LOAD: wdata = load_data;
      WB_PC4:  wdata = WORD_LEN'(wb_q.pc + ADDR_SIZE'(4));
      WB_IMM:  wdata = wb_q.imm;
      default: wdata = wb_q.alu;
    endcase
  end

  assign dest_live   = wb_q.valid & wb_q.reg_write & (wb_q.rd != '0);
  assign writeEnable = dest_live & wb_q.first;
  assign writeAddr   = wb_q.rd;
  assign writeData   = wdata;
  assign pc          = wb_q.pc;
  assign fwdValid    = dest_live;
  assign fwdAddr     = wb_q.rd;
  assign fwdData     = wdata;

`ifdef MEM_WB_INSTRET_EN
  logic [63:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (wb_q.valid && wb_q.first) begin
      retired_d = retired_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retiredCount = retired_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized
// traffic compared against an instruction-level reference model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, inValid, stall, flush, inRegWrite;
  logic [31:0] inPc, inAluResult, inImm, inMemData;
  logic [4:0]  inRd;
  logic [1:0]  inWbSel;
  logic [2:0]  inMemFunct3;
  logic        writeEnable, fwdValid;
  logic [4:0]  writeAddr, fwdAddr;
  logic [31:0] writeData, pc, fwdData;
`ifdef MEM_WB_INSTRET_EN
  logic [63:0] retiredCount;
  longint unsigned ret_before;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk         (clk),
    .reset       (reset),
    .inValid     (inValid),
    .stall       (stall),
    .flush       (flush),
    .inPc        (inPc),
    .inRd        (inRd),
    .inRegWrite  (inRegWrite),
    .inWbSel     (inWbSel),
    .inAluResult (inAluResult),
    .inImm       (inImm),
    .inMemData   (inMemData),
    .inMemFunct3 (inMemFunct3),
    .writeEnable (writeEnable),
    .writeAddr   (writeAddr),
    .writeData   (writeData),
    .pc          (pc),
    .fwdValid    (fwdValid),
    .fwdAddr     (fwdAddr),
    .fwdData     (fwdData)
`ifdef MEM_WB_INSTRET_EN
    , .retiredCount(retiredCount)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                       input logic [1:0] sel, input logic [31:0] p,
                       input logic [31:0] alu, input logic [31:0] imm,
                       input logic [31:0] mem, input logic [2:0] f3);
    inValid = v; inRd = rd; inRegWrite = rw; inWbSel = sel; inPc = p;
    inAluResult = alu; inImm = imm; inMemData = mem; inMemFunct3 = f3;
  endtask

  // Reference value written back for one instruction, from the ISA load rules.
  function automatic logic [31:0] ref_wdata(input logic [1:0] sel, input logic [31:0] p,
                                            input logic [31:0] alu, input logic [31:0] imm,
                                            input logic [31:0] mem, input logic [2:0] f3);
    logic [31:0] b, h;
    b = (mem >> (8 * alu[1:0])) & 32'hFF;
    h = (mem >> (16 * alu[1])) & 32'hFFFF;
    case (sel)
      2'b00: return alu;
      2'b10: return p + 32'd4;
      2'b11: return imm;
      default: begin
        case (f3)
          3'b000: return b[7] ? (b | 32'hFFFFFF00) : b;
          3'b001: return h[15] ? (h | 32'hFFFF0000) : h;
          3'b100: return b;
          3'b101: return h;
          default: return mem;
        endcase
      end
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 5'd9, 1'b1, 2'b11, 32'h1234, 32'h55, 32'hAA, 32'h77, 3'b010);
    tick(); tick();
    total++;
    if ({writeEnable, fwdValid, writeAddr, writeData, pc, fwdAddr, fwdData} !== '0) begin
      bad++;
      $display("FAIL reset_outputs we=%b fv=%b wa=%0d wd=%h pc=%h", writeEnable, fwdValid, writeAddr, writeData, pc);
    end
`ifdef MEM_WB_INSTRET_EN
    total++;
    if (retiredCount !== 64'd0) begin bad++; $display("FAIL reset_retired got=%0d want=0", retiredCount); end
`endif
    reset = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000);
    tick();
  endtask

  task automatic test_lb();
    drive(1'b1, 5'd7, 1'b1, 2'b01, 32'h400, 32'h1003, 32'h0, 32'h80FF1234, 3'b000);
    tick();
    total++;
    if (writeEnable !== 1'b1) begin bad++; $display("FAIL lb_we got=%b want=1", writeEnable); end
    total++;
    if (writeData !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got=%h want=ffffff80", writeData); end
    total++;
    if (writeAddr !== 5'd7 || pc !== 32'h400) begin bad++; $display("FAIL lb_addr_pc got=%0d/%h want=7/400", writeAddr, pc); end
    drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000);
    tick();
  endtask

  task automatic test_lhu();
    drive(1'b1, 5'd3, 1'b1, 2'b01, 32'h500, 32'h2002, 32'h0, 32'hBEEF0000, 3'b101);
    tick();
    total++;
    if (writeData !== 32'h0000BEEF || writeEnable !== 1'b1) begin
      bad++; $display("FAIL lhu_data got=%h we=%b want=0000beef we=1", writeData, writeEnable);
    end
    // Halfword with odd address: bit 0 ignored, signed extension of upper half.
    drive(1'b1, 5'd3, 1'b1, 2'b01, 32'h500, 32'h2003, 32'h0, 32'hBEEF0000, 3'b001);
    tick();
    total++;
    if (writeData !== 32'hFFFFBEEF) begin bad++; $display("FAIL lh_misaligned got=%h want=ffffbeef", writeData); end
    drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000);
    tick();
  endtask

  task automatic test_jal();
    drive(1'b1, 5'd1, 1'b1, 2'b10, 32'h00000FFC, 32'h0, 32'h0, 32'h0, 3'b000);
    tick();
    total++;
    if (writeData !== 32'h00001000 || writeAddr !== 5'd1 || writeEnable !== 1'b1) begin
      bad++; $display("FAIL jal_link got wd=%h wa=%0d we=%b want 00001000/1/1", writeData, writeAddr, writeEnable);
    end
    drive(1'b1, 5'd2, 1'b1, 2'b10, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 3'b000);
    tick();
    total++;
    if (writeData !== 32'h0) begin bad++; $display("FAIL jal_wrap got=%h want=0", writeData); end
    drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000);
    tick();
  endtask

  task automatic test_rd0();
    drive(1'b1, 5'd0, 1'b1, 2'b00, 32'h600, 32'h5, 32'h0, 32'h0, 3'b000);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (writeEnable !== 1'b0 || fwdValid !== 1'b0) begin
        bad++; $display("FAIL rd0_cycle%0d we=%b fv=%b want 0/0", i, writeEnable, fwdValid);
      end
      tick();
    end
    stall = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000);
    tick();
  endtask

  task automatic test_stall();
`ifdef MEM_WB_INSTRET_EN
    ret_before = retiredCount;
`endif
    drive(1'b1, 5'd5, 1'b1, 2'b11, 32'h700, 32'h0, 32'hCAFE0005, 32'h0, 3'b000);
    tick();
    stall = 1'b1;
    drive(1'b1, 5'd9, 1'b1, 2'b00, 32'h800, 32'h99, 32'h0, 32'h0, 3'b000);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (writeEnable !== (i == 0) || fwdValid !== 1'b1 || writeAddr !== 5'd5 ||
          fwdData !== 32'hCAFE0005 || pc !== 32'h700) begin
        bad++;
        $display("FAIL stall_cycle%0d we=%b fv=%b wa=%0d fd=%h pc=%h want we=%0d fv=1 wa=5 fd=cafe0005 pc=700",
                 i, writeEnable, fwdValid, writeAddr, fwdData, pc, (i == 0));
      end
      if (i < 3) tick();
    end
`ifdef MEM_WB_INSTRET_EN
    total++;
    if (retiredCount !== ret_before + 1) begin
      bad++; $display("FAIL stall_retired got=%0d want=%0d", retiredCount, ret_before + 1);
    end
`endif
    stall = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000);
    tick();
  endtask

  task automatic test_flush_reset();
    drive(1'b1, 5'd4, 1'b1, 2'b00, 32'h900, 32'h44, 32'h0, 32'h0, 3'b000);
    tick();
    stall = 1'b1; flush = 1'b1;
    tick();
    total++;
    if (writeEnable !== 1'b0 || fwdValid !== 1'b0) begin
      bad++; $display("FAIL flush_stall we=%b fv=%b want 0/0", writeEnable, fwdValid);
    end
    flush = 1'b0; stall = 1'b0;
    drive(1'b1, 5'd6, 1'b1, 2'b11, 32'hA00, 32'h0, 32'h66, 32'h0, 3'b000);
    tick();
    stall = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    total++;
    if ({writeEnable, fwdValid, writeAddr, writeData, pc, fwdAddr, fwdData} !== '0) begin
      bad++; $display("FAIL reset_mid_stall we=%b fv=%b wa=%0d wd=%h pc=%h want all 0", writeEnable, fwdValid, writeAddr, writeData, pc);
    end
    reset = 1'b0; stall = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000);
    tick();
  endtask

  task automatic test_random();
    logic        m_valid, m_written, m_rw;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [2:0]  m_f3;
    logic [31:0] m_pc, m_alu, m_imm, m_mem, exp_d;
    logic        exp_we, exp_fv;
    longint unsigned m_ret;
    m_valid = 0; m_written = 1; m_rw = 0; m_rd = 0; m_sel = 0; m_f3 = 0;
    m_pc = 0; m_alu = 0; m_imm = 0; m_mem = 0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    tick();
    m_ret = 0;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 11) == 0);
      stall = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 3) != 0, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            1'($urandom), 2'($urandom), $urandom, $urandom, $urandom, $urandom, 3'($urandom));
      // An instruction retires at the edge ending its first visible cycle.
      if (reset) m_ret = 0;
      else if (m_valid && !m_written) m_ret++;
      if (reset || flush) begin
        m_valid = 0; m_written = 1;
      end else if (stall) begin
        m_written = 1;
      end else begin
        m_valid = inValid; m_written = 0; m_rd = inRd; m_rw = inRegWrite; m_sel = inWbSel;
        m_pc = inPc; m_alu = inAluResult; m_imm = inImm; m_mem = inMemData; m_f3 = inMemFunct3;
      end
      tick();
      exp_fv = m_valid && m_rw && (m_rd != 0);
      exp_we = exp_fv && !m_written;
      exp_d  = ref_wdata(m_sel, m_pc, m_alu, m_imm, m_mem, m_f3);
      total++;
      if (writeEnable !== exp_we || fwdValid !== exp_fv) begin
        bad++; $display("FAIL rand%0d_ctrl we=%b fv=%b want %b/%b", i, writeEnable, fwdValid, exp_we, exp_fv);
      end
      if (m_valid) begin
        total++;
        if (writeData !== exp_d || fwdData !== exp_d || writeAddr !== m_rd || fwdAddr !== m_rd || pc !== m_pc) begin
          bad++; $display("FAIL rand%0d_data wd=%h wa=%0d pc=%h want %h/%0d/%h", i, writeData, writeAddr, pc, exp_d, m_rd, m_pc);
        end
      end
`ifdef MEM_WB_INSTRET_EN
      total++;
      if (retiredCount !== m_ret) begin bad++; $display("FAIL rand%0d_retired got=%0d want=%0d", i, retiredCount, m_ret); end
`endif
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000);
    test_reset();
    test_lb();
    test_lhu();
    test_jal();
    test_rd0();
    test_stall();
    test_flush_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
